// File: rtl/rv_dmem_if.sv
// Datapath-to-data-memory request/response bundle.
// The datapath drives the master side and the memory drives the slave side.
interface rv_dmem_if #(
  parameter int DPWIDTH = 32
);
  logic                   req;
  logic                   we;
  logic [DPWIDTH-1:0]     addr;
  logic [DPWIDTH-1:0]     wdata;
  logic [DPWIDTH/8-1:0]   be;
  logic [DPWIDTH-1:0]     rdata;
  logic                   ready;
  logic                   busy;
  logic                   err;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/rv_dmem.sv
// Byte-enabled data memory: one access at a time, ready pulses LATENCY+1 cycles after acceptance.
// Requests are ignored while busy; RV_DMEM_ERR_EN enables misaligned/out-of-range error flagging.
module rv_dmem #(
  parameter int DPWIDTH  = 32,
  parameter int MEMWORDS = 1024,
  parameter int LATENCY  = 2
) (
  input  logic      clk,
  input  logic      rst,
  rv_dmem_if.slave  bus
);
  localparam int AW = $clog2(MEMWORDS);
  localparam int BW = DPWIDTH / 8;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 we_q;
  logic [DPWIDTH-1:0]   addr_q;
  logic [DPWIDTH-1:0]   wdata_q;
  logic [BW-1:0]        be_q;
  logic [DPWIDTH-1:0]   rdata;
  logic                 ready;
  logic                 busy;
  logic                 err;

  logic [DPWIDTH-1:0]   mem [MEMWORDS];

  logic                 a_we;
  logic [DPWIDTH-1:0]   a_addr;
  logic [DPWIDTH-1:0]   a_wdata;
  logic [BW-1:0]        a_be;
  logic                 a_err;
  logic [AW-1:0]        idx;
  logic                 enter_resp;
  logic                 mem_we;

  // With LATENCY=0 the response edge is the acceptance edge, so live inputs are used in IDLE.
  always_comb begin
    a_we    = (state == IDLE) ? bus.we    : we_q;
    a_addr  = (state == IDLE) ? bus.addr  : addr_q;
    a_wdata = (state == IDLE) ? bus.wdata : wdata_q;
    a_be    = (state == IDLE) ? bus.be    : be_q;
  end

  assign idx        = a_addr[AW+1:2];
  assign enter_resp = ((state == IDLE) && bus.req && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1));
  assign mem_we     = enter_resp && !rst && a_we && !a_err;

`ifdef RV_DMEM_ERR_EN
  assign a_err = (a_addr[1:0] != 2'b00) || ((a_addr >> (AW + 2)) != '0);
`else
  logic unused_addr;
  assign unused_addr = ^a_addr;
  assign a_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            be_q    <= bus.be;
            busy    <= 1'b1;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        ready <= 1'b1;
        err   <= a_err;
        if (!a_we && !a_err) rdata <= mem[idx];
      end
    end
  end

  assign bus.rdata = rdata;
  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.err   = err;
endmodule

// File: tb/tb_rv_dmem.sv
// Directed bench for rv_dmem at LATENCY=2; define RV_DMEM_ERR_EN for both bench and RTL to check the error path.
module tb_rv_dmem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  rv_dmem_if #(.DPWIDTH(32)) bus ();

  rv_dmem #(.DPWIDTH(32), .MEMWORDS(1024), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Starts a request in the current cycle, then samples each following cycle at the falling edge.
  // Returns at the falling edge of the cycle after the response, so a caller can issue back-to-back.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input bit poke,
                           output int lat, output logic [31:0] rd, output logic er,
                           output logic bz, output logic rdy_after);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    @(posedge clk); #1;
    if (poke) begin
      bus.addr = 32'h40; bus.we = 1'b1; bus.wdata = 32'h0BAD0BAD; bus.be = 4'hF;
    end else begin
      bus.req = 1'b0;
    end
    lat = 0; rd = 'x; er = 1'bx; bz = 1'b0; rdy_after = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bz = bus.busy;
      if (lat != 0) begin
        rdy_after = bus.ready;
        break;
      end
      if (bus.ready) begin
        lat = k; rd = bus.rdata; er = bus.err;
      end
      if (k == 2) bus.req = 1'b0;
    end
    bus.req = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er, bz, ra;

  task automatic test_reset();
    rst = 1'b1; bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=00000000", bus.rdata); end
  endtask

  task automatic test_write_read();
    do_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd, er, bz, ra);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (bz !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", bz); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL wr_ready_pulse got=%b exp=0", ra); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_rdata_held got=%h exp=00000000", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", er); end
    do_access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er, bz, ra);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_partial_write();
    do_access(1'b1, 32'h10, 32'h0000AA00, 4'h2, 1'b0, lat, rd, er, bz, ra);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL pw_rdata_held got=%h exp=deadbeef", rd); end
    do_access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er, bz, ra);
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL pw_data got=%h exp=deadaaef", rd); end
    do_access(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, lat, rd, er, bz, ra);
    checks++; if (lat !== 3) begin failures++; $display("FAIL be0_latency got=%0d exp=3", lat); end
    do_access(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, rd, er, bz, ra);
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL be0_data got=%h exp=deadaaef", rd); end
  endtask

  task automatic test_req_while_busy();
    do_access(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, lat, rd, er, bz, ra);
    do_access(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, lat, rd, er, bz, ra);
    checks++; if (lat !== 3) begin failures++; $display("FAIL busy_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL busy_data got=%h exp=deadaaef", rd); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL busy_single_ready got=%b exp=0", ra); end
    do_access(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, lat, rd, er, bz, ra);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL busy_0x40_untouched got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 32'h24, 32'h55AA55AA, 4'hF, 1'b0, lat, rd, er, bz, ra);
    do_access(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, lat, rd, er, bz, ra);
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL b2b_data got=%h exp=55aa55aa", rd); end
  endtask

  task automatic test_misalign();
    do_access(1'b0, 32'h13, 32'h0, 4'hF, 1'b0, lat, rd, er, bz, ra);
    checks++; if (lat !== 3) begin failures++; $display("FAIL mis_latency got=%0d exp=3", lat); end
`ifdef RV_DMEM_ERR_EN
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL mis_rdata_held got=%h exp=55aa55aa", rd); end
    do_access(1'b1, 32'h1010, 32'h12345678, 4'hF, 1'b0, lat, rd, er, bz, ra);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", er); end
    do_access(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, rd, er, bz, ra);
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL oor_write_suppressed got=%h exp=deadaaef", rd); end
`else
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL mis_err got=%b exp=0", er); end
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL mis_data got=%h exp=deadaaef", rd); end
    do_access(1'b0, 32'h1024, 32'h0, 4'hF, 1'b0, lat, rd, er, bz, ra);
    checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL alias_data got=%h exp=55aa55aa", rd); end
`endif
  endtask

  task automatic test_reset_mid_access();
    int nrdy;
    do_access(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0, lat, rd, er, bz, ra);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h22222222; bus.be = 4'hF;
    @(posedge clk); #1;
    bus.req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nrdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
      end
      if (bus.ready === 1'b1) nrdy++;
    end
    checks++; if (nrdy !== 0) begin failures++; $display("FAIL midrst_ready got=%0d pulses exp=0", nrdy); end
    do_access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, lat, rd, er, bz, ra);
    checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL midrst_data got=%h exp=11111111", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_req_while_busy();
    test_back_to_back();
    test_misalign();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
